// File: rtl/text_refresh_arbiter.sv
// Round-robin write arbiter for an overlay text buffer. Accepted writes are
// coalesced into bursts, and the overlay refresh runs through a start/idle handshake.
module text_refresh_arbiter #(
    parameter int NUM_CHAR  = 300,
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 32
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst_n,
    input  logic [NUM_REQ-1:0]                       i_req,
    input  logic [NUM_REQ-1:0][$clog2(NUM_CHAR)-1:0] i_req_addr,
    input  logic [NUM_REQ-1:0][7:0]                  i_req_char,
    output logic [NUM_REQ-1:0]                       o_gnt,
    output logic                                     o_addr_err,
    output logic [NUM_CHAR-1:0][7:0]                 o_characters,
    output logic                                     o_wr_ready,
    input  logic                                     i_wr_completed,
    output logic                                     o_busy
);
    localparam int AW      = $clog2(NUM_CHAR);
    localparam int BW      = $clog2(MAX_BURST + 1);
    localparam int PW      = $clog2(NUM_REQ);
    localparam int TIMEOUT = 4;

    typedef enum logic [1:0] {ACCEPT, LAUNCH, WAIT_START, WAIT_DONE} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [NUM_CHAR-1:0][7:0] r_chars;
    logic                     r_dirty;
    logic [BW-1:0]            r_burst_cnt;
    logic [PW-1:0]            r_rr_ptr;
    logic [1:0]               r_wait_cnt;
    logic                     r_addr_err;

    logic          w_full;
    logic          w_launch;
    logic          w_gnt_vld;
    logic          w_take;
    logic          w_addr_ok;
    logic [PW-1:0] w_gnt_idx;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] w_wr_idx;
    logic [7:0]    w_char;
    int            w_rr_k;

    // Scan from the far end so the requester closest to r_rr_ptr is written last and wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_rr_k    = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_rr_k = int'(r_rr_ptr) + i;
            if (w_rr_k >= NUM_REQ) w_rr_k = w_rr_k - NUM_REQ;
            if (i_req[PW'(w_rr_k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PW'(w_rr_k);
            end
        end
    end

    assign w_full    = (r_burst_cnt == BW'(MAX_BURST));
    assign w_launch  = (r_state == ACCEPT) && r_dirty && i_wr_completed && (~|i_req || w_full);
    assign w_take    = (r_state == ACCEPT) && !w_full && w_gnt_vld && i_rst_n;
    assign w_addr    = i_req_addr[w_gnt_idx];
    assign w_char    = i_req_char[w_gnt_idx];
    assign w_addr_ok = ({1'b0, w_addr} < (AW+1)'(NUM_CHAR));
    assign w_wr_idx  = AW'(NUM_CHAR - 1) - w_addr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACCEPT:     if (w_launch) w_next = LAUNCH;
            LAUNCH:     w_next = WAIT_START;
            // The launch cycle counts toward the timeout, so a re-pulse lands 4 cycles after the last one.
            WAIT_START: if (!i_wr_completed) w_next = WAIT_DONE;
                        else if (r_wait_cnt == 2'(TIMEOUT - 2)) w_next = LAUNCH;
            WAIT_DONE:  if (i_wr_completed) w_next = ACCEPT;
            default:    w_next = ACCEPT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ACCEPT;
            r_chars     <= {NUM_CHAR{8'h20}};
            r_dirty     <= 1'b1;
            r_burst_cnt <= '0;
            r_rr_ptr    <= '0;
            r_wait_cnt  <= '0;
            r_addr_err  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_addr_err <= w_take && !w_addr_ok;
            r_wait_cnt <= (r_state == WAIT_START) ? r_wait_cnt + 1'b1 : '0;
            if (w_take) begin
                r_rr_ptr <= (w_gnt_idx == PW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                if (w_addr_ok) begin
                    r_chars[w_wr_idx] <= w_char;
                    r_dirty           <= 1'b1;
                    r_burst_cnt       <= r_burst_cnt + 1'b1;
                end
            end
            if (r_state == LAUNCH) begin
                r_dirty     <= 1'b0;
                r_burst_cnt <= '0;
            end
        end
    end

    assign o_gnt        = w_take ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign o_addr_err   = r_addr_err;
    assign o_characters = r_chars;
    assign o_wr_ready   = (r_state == LAUNCH);
    assign o_busy       = (r_state != ACCEPT);

endmodule

// File: tb/tb_text_refresh_arbiter.sv
// Directed bench for text_refresh_arbiter with a small overlay model that
// answers each refresh pulse by going busy for a programmable number of cycles.
module tb_text_refresh_arbiter;
    localparam int NUM_CHAR = 300;
    localparam int NUM_REQ  = 2;
    localparam int AW       = 9;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0][AW-1:0]     req_addr;
    logic [NUM_REQ-1:0][7:0]        req_char;
    logic [NUM_REQ-1:0]             gnt;
    logic                           addr_err;
    logic [NUM_CHAR-1:0][7:0]       chars;
    logic                           wr_ready;
    logic                           wr_completed = 1'b1;
    logic                           busy;

    int n_checks = 0;
    int n_errors = 0;

    // Overlay model: ov_force >= 0 pins the idle flag, -1 lets it react to pulses.
    int ov_force       = 1;
    int ov_len         = 3;
    int ov_cnt         = 0;
    int ov_ignore_upto = 0;
    int ov_ignored     = 0;
    int pulses         = 0;
    int cyc            = 0;
    int pulse_cyc_last = 0;
    int pulse_cyc_prev = 0;

    always #5 clk = ~clk;

    text_refresh_arbiter #(.NUM_CHAR(NUM_CHAR), .NUM_REQ(NUM_REQ), .MAX_BURST(32)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req          (req),
        .i_req_addr     (req_addr),
        .i_req_char     (req_char),
        .o_gnt          (gnt),
        .o_addr_err     (addr_err),
        .o_characters   (chars),
        .o_wr_ready     (wr_ready),
        .i_wr_completed (wr_completed),
        .o_busy         (busy)
    );

    always @(negedge clk) begin
        cyc++;
        if (wr_ready) begin
            pulses++;
            pulse_cyc_prev = pulse_cyc_last;
            pulse_cyc_last = cyc;
        end
        if (ov_force >= 0) begin
            wr_completed = ov_force[0];
            ov_cnt       = 0;
        end else if (ov_cnt > 0) begin
            ov_cnt--;
            if (ov_cnt == 0) wr_completed = 1'b1;
        end else if (wr_ready) begin
            if (ov_ignored < ov_ignore_upto) ov_ignored++;
            else begin
                wr_completed = 1'b0;
                ov_cnt       = ov_len;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int g;
        int p0;
        int first_g;
        int bad_gnt;

        rst_n    = 1'b0;
        req      = 2'b11;
        req_addr = '0;
        req_char = '0;
        repeat (2) tick();

        // Reset state
        check("rst_gnt", gnt, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_addr_err", addr_err, 0);
        check("rst_busy", busy, 0);
        bad = 0;
        for (int c = 0; c < NUM_CHAR; c++) if (chars[c] !== 8'h20) bad++;
        check("rst_blank_cells", bad, 0);

        // First refresh straight after release
        req      = 2'b00;
        rst_n    = 1'b1;
        ov_force = -1;
        p0       = pulses;
        tick();
        check("boot_pulse", wr_ready, 1);
        check("boot_busy", busy, 1);
        tick();
        check("boot_pulse_one_cycle", wr_ready, 0);
        wait_idle("boot_idle", 20);
        check("boot_pulse_cnt", pulses - p0, 1);

        // Two held requests, round-robin, then coalesced refresh
        req_addr[0] = 9'd5;
        req_addr[1] = 9'd6;
        req_char[0] = 8'h41;
        req_char[1] = 8'h42;
        req         = 2'b11;
        #1;
        check("rr_first", gnt, 2'b01);
        tick();
        check("rr_second", gnt, 2'b10);
        check("wr_cell294", chars[294], 8'h41);
        tick();
        req = 2'b00;
        #1;
        check("wr_cell293", chars[293], 8'h42);
        check("no_pulse_during_burst", wr_ready, 0);
        p0 = pulses;
        tick();
        check("coalesce_pulse", wr_ready, 1);
        wait_idle("coalesce_idle", 20);
        check("coalesce_pulse_cnt", pulses - p0, 1);

        // Out-of-range address
        req_addr[0] = 9'd300;
        req_char[0] = 8'h55;
        req         = 2'b01;
        #1;
        check("bad_addr_gnt", gnt, 2'b01);
        tick();
        req = 2'b00;
        #1;
        check("addr_err_pulse", addr_err, 1);
        check("bad_addr_cell294", chars[294], 8'h41);
        check("bad_addr_cell0", chars[0], 8'h20);
        p0 = pulses;
        tick();
        check("addr_err_one_cycle", addr_err, 0);
        check("bad_addr_no_launch", busy, 0);
        tick();
        tick();
        check("bad_addr_no_pulse", pulses - p0, 0);

        // 40-write stream from requester 0 with forced refresh at 32
        g       = 0;
        first_g = -1;
        bad_gnt = 0;
        p0      = pulses;
        for (int c = 0; c < 400; c++) begin
            if (g >= 40 && !busy && (pulses - p0) >= 2) break;
            req         = (g < 40) ? 2'b01 : 2'b00;
            req_addr[0] = AW'(g);
            req_char[0] = 8'(8'h60 + g);
            #1;
            if (wr_ready && first_g < 0) first_g = g;
            if (busy && gnt != 0) bad_gnt++;
            if (gnt[0]) g++;
            tick();
        end
        req = 2'b00;
        check("stream_grants", g, 40);
        check("stream_forced_at", first_g, 32);
        check("stream_no_gnt_busy", bad_gnt, 0);
        check("stream_pulse_cnt", pulses - p0, 2);
        check("stream_idle", busy, 0);
        check("stream_cell299", chars[299], 8'h60);
        check("stream_cell268", chars[268], 8'h7F);
        check("stream_cell260", chars[260], 8'h87);

        // Overlay ignores the first pulse
        ov_ignore_upto = ov_ignored + 1;
        req_addr[1]    = 9'd10;
        req_char[1]    = 8'h33;
        req            = 2'b10;
        #1;
        check("ign_gnt", gnt, 2'b10);
        tick();
        req = 2'b00;
        p0  = pulses;
        tick();
        check("ign_first_pulse", wr_ready, 1);
        wait_idle("ign_idle", 40);
        check("ign_pulse_cnt", pulses - p0, 2);
        check("ign_repulse_gap", pulse_cyc_last - pulse_cyc_prev, 4);
        check("ign_cell289", chars[289], 8'h33);

        // Reset during WAIT_DONE
        ov_len      = 10;
        req_addr[0] = 9'd0;
        req_char[0] = 8'h7E;
        req         = 2'b01;
        #1;
        check("mid_gnt", gnt, 2'b01);
        tick();
        req = 2'b00;
        tick();
        check("mid_launch", wr_ready, 1);
        repeat (3) tick();
        check("mid_pre_busy", busy, 1);
        check("mid_pre_cell299", chars[299], 8'h7E);
        ov_force = 0;
        rst_n    = 1'b0;
        req      = 2'b11;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wr_ready", wr_ready, 0);
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_cell299", chars[299], 8'h20);
        tick();
        rst_n = 1'b1;
        req   = 2'b00;
        ov_len = 3;
        p0    = pulses;
        repeat (3) tick();
        check("mid_no_launch_while_busy", pulses - p0, 0);
        check("mid_accept_while_busy", busy, 0);
        ov_force = 1;
        tick();
        check("mid_relaunch", wr_ready, 1);
        ov_force = -1;
        wait_idle("mid_idle", 40);
        check("mid_pulse_cnt", pulses - p0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/text_refresh_arbiter.md
TEXT_REFRESH_ARBITER -- requirements
Module: text_refresh_arbiter

Interface
REQ-001 Parameter NUM_CHAR, default 300: character cells held in the text buffer.
REQ-002 Parameter NUM_REQ, default 2: number of write requesters (2..8).
REQ-003 Parameter MAX_BURST, default 32: maximum accepted writes before a refresh is forced.
REQ-004 i_clk  in  1: single clock; all logic on rising edge.
REQ-005 i_rst_n  in  1: reset, asynchronous, active-low.
REQ-006 i_req  in  NUM_REQ: per-requester write request, held until granted.
REQ-007 i_req_addr  in  NUM_REQ x $clog2(NUM_CHAR): cell position p (row-major, 0 = top-left).
REQ-008 i_req_char  in  NUM_REQ x 8: character code for that cell.
REQ-009 o_gnt  out  NUM_REQ: one-hot grant, combinational from i_req, state and pointer; the write is taken on the same edge.
REQ-010 o_addr_err  out  1: one-cycle pulse when a granted address is >= NUM_CHAR.
REQ-011 o_characters  out  NUM_CHAR x 8: buffer driven to the overlay's character input.
REQ-012 o_wr_ready  out  1: refresh start pulse to the overlay.
REQ-013 i_wr_completed  in  1: overlay idle flag (high = idle, low = refresh in progress).
REQ-014 o_busy  out  1: high in any state other than ACCEPT.

Function
REQ-015 States: ACCEPT, LAUNCH, WAIT_START, WAIT_DONE.
REQ-016 ACCEPT: at most one grant per cycle, round-robin; priority starts at index rr_ptr, and after a grant to k, rr_ptr <= (k+1) mod NUM_REQ.
REQ-017 Granted write with p < NUM_CHAR: o_characters[NUM_CHAR-1-p] <= char (reversed index matches the overlay's read order); dirty <= 1; burst_cnt <= burst_cnt+1.
REQ-018 Granted write with p >= NUM_CHAR: buffer unchanged, dirty/burst_cnt unchanged, o_addr_err = 1 next cycle for one cycle.
REQ-019 ACCEPT -> LAUNCH when dirty=1 and i_wr_completed=1 and either no i_req bit is set this cycle (burst coalescing) or burst_cnt == MAX_BURST (forced refresh; no grant issued that cycle).
REQ-020 LAUNCH: o_wr_ready = 1 for exactly one cycle; dirty <= 0; burst_cnt <= 0; next state WAIT_START.
REQ-021 WAIT_START: wait for i_wr_completed = 0, then go to WAIT_DONE; if it stays high for 4 cycles, return to LAUNCH (re-pulse).
REQ-022 WAIT_DONE: wait for i_wr_completed = 1, then go to ACCEPT.
REQ-023 In LAUNCH, WAIT_START and WAIT_DONE, o_gnt = 0 and o_characters is frozen (the overlay samples it throughout its refresh).
REQ-024 Requests arriving while busy are not lost: requesters hold i_req, and the requests are granted in round-robin order after the return to ACCEPT.
REQ-025 Repeated writes to the same cell within one burst: the last write wins; one refresh covers them all.
REQ-026 burst_cnt saturates at MAX_BURST, and its width is $clog2(MAX_BURST+1).
REQ-027 If dirty=1 but i_wr_completed=0 in ACCEPT, stay in ACCEPT and keep granting until the overlay goes idle, bounded by MAX_BURST.

Reset
REQ-028 On i_rst_n low, immediately: state ACCEPT, all o_characters bytes 8'h20 (space), dirty=1, burst_cnt=0, rr_ptr=0, o_wr_ready=0, o_addr_err=0; o_gnt=0 while reset is asserted.
REQ-029 After release, with i_wr_completed=1 and no requests, the first refresh launches on the first edge, blanking the screen.
REQ-030 Reset asserted mid-refresh: abort to ACCEPT with dirty=1, so the overlay is refreshed again once it reports idle.

Verification
REQ-031 Reset release, overlay idle, no requests -> o_wr_ready pulses 1 cycle; all 300 bytes = 8'h20; overlay model drops completed for N cycles then raises it; FSM returns to ACCEPT.
REQ-032 i_req=2'b11 held, addrs 5/6, chars 8'h41/8'h42 -> gnt 01 then 10; o_characters[294]=8'h41, [293]=8'h42; one o_wr_ready pulse follows on the first request-free cycle.
REQ-033 Requester 0 streams 40 writes back-to-back, MAX_BURST=32 -> forced LAUNCH after the 32nd grant; no grant during the refresh; the remaining 8 writes are granted after WAIT_DONE, followed by a second refresh.
REQ-034 Write addr 300 (NUM_CHAR=300) -> gnt issued, o_addr_err pulses once, buffer unchanged, no refresh triggered.
REQ-035 Overlay model ignores the first o_wr_ready (completed stays high) -> o_wr_ready re-pulses 4 cycles later; refresh then completes normally.
REQ-036 i_rst_n low during WAIT_DONE -> outputs at reset values immediately; after release a new o_wr_ready is issued only once i_wr_completed=1.
